// File: rtl/recv_logic_if.sv
`default_nettype none
// ============================================================================
// Module      : recv_logic_if
// Description : FWFT FIFO read-side bundle feeding recv_logic
//               (four control FIFOs plus the pixel FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
interface recv_logic_if #(
    parameter int BUFF_SIZE     = 32,
    parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
    parameter int DATA_WIDTH    = 8
);
    logic                     recv_buff_size_empty;
    logic                     recv_pivot_empty;
    logic                     recv_median_pos_empty;
    logic                     recv_second_median_value_empty;
    logic                     recv_px_empty;
    logic [BUFF_SIZE_BIT-1:0] recv_buff_size_din;
    logic [DATA_WIDTH-1:0]    recv_pivot_din;
    logic [BUFF_SIZE_BIT-1:0] recv_median_pos_din;
    logic [DATA_WIDTH-1:0]    recv_second_median_value_din;
    logic [DATA_WIDTH-1:0]    recv_px_din;
    logic                     recv_buff_size_rd;
    logic                     recv_pivot_rd;
    logic                     recv_median_pos_rd;
    logic                     recv_second_median_value_rd;
    logic                     recv_px_rd;

    // FIFO side
    modport master (
        output recv_buff_size_empty, recv_pivot_empty, recv_median_pos_empty,
               recv_second_median_value_empty, recv_px_empty,
               recv_buff_size_din, recv_pivot_din, recv_median_pos_din,
               recv_second_median_value_din, recv_px_din,
        input  recv_buff_size_rd, recv_pivot_rd, recv_median_pos_rd,
               recv_second_median_value_rd, recv_px_rd
    );

    // Consumer side (recv_logic)
    modport slave (
        input  recv_buff_size_empty, recv_pivot_empty, recv_median_pos_empty,
               recv_second_median_value_empty, recv_px_empty,
               recv_buff_size_din, recv_pivot_din, recv_median_pos_din,
               recv_second_median_value_din, recv_px_din,
        output recv_buff_size_rd, recv_pivot_rd, recv_median_pos_rd,
               recv_second_median_value_rd, recv_px_rd
    );
endinterface
`default_nettype wire

// File: rtl/recv_logic.sv
`default_nettype none
// ============================================================================
// Module      : recv_logic
// Description : Pops one burst header from the control FIFOs, then exactly
//               buff_size pixels into the local pixel buffer, then pulses
//               recv_done. Optional macro RECV_LOGIC_SIZE_CHECK_EN enables
//               the sticky recv_size_err check.
// Revision    : 1.0 - initial release
// ============================================================================
module recv_logic #(
    parameter int BUFF_SIZE     = 32,
    parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     recv_req,
    recv_logic_if.slave              fifo,
    output logic [BUFF_SIZE_BIT-1:0] buff_size,
    output logic [DATA_WIDTH-1:0]    pivot,
    output logic [BUFF_SIZE_BIT-1:0] median_pos,
    output logic [DATA_WIDTH-1:0]    second_median_value,
    output logic                     buf_wr,
    output logic [BUFF_SIZE_BIT-1:0] buf_addr,
    output logic [DATA_WIDTH-1:0]    buf_data,
    output logic                     receiving,
    output logic                     recv_done,
    output logic [BUFF_SIZE_BIT-1:0] recv_count,
    output logic                     recv_size_err
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RECV = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [BUFF_SIZE_BIT-1:0] c_BUFF_SIZE = BUFF_SIZE_BIT'(BUFF_SIZE);
    localparam logic [BUFF_SIZE_BIT-1:0] c_ONE       = BUFF_SIZE_BIT'(1);

    logic [1:0]               r_state;
    logic [BUFF_SIZE_BIT-1:0] r_buff_size;
    logic [DATA_WIDTH-1:0]    r_pivot;
    logic [BUFF_SIZE_BIT-1:0] r_median_pos;
    logic [DATA_WIDTH-1:0]    r_second;
    logic [BUFF_SIZE_BIT-1:0] r_count;

    logic w_hdr_ok;
    logic w_px_rd;
    logic w_buf_wr;

    // rst_n gates the header strobe so nothing is popped while held in reset
    assign w_hdr_ok = rst_n && (r_state == c_ST_IDLE) && recv_req &&
                      !fifo.recv_buff_size_empty && !fifo.recv_pivot_empty &&
                      !fifo.recv_median_pos_empty && !fifo.recv_second_median_value_empty;
    assign w_px_rd  = (r_state == c_ST_RECV) && !fifo.recv_px_empty;
    assign w_buf_wr = w_px_rd && (r_count < c_BUFF_SIZE);

    assign fifo.recv_buff_size_rd           = w_hdr_ok;
    assign fifo.recv_pivot_rd               = w_hdr_ok;
    assign fifo.recv_median_pos_rd          = w_hdr_ok;
    assign fifo.recv_second_median_value_rd = w_hdr_ok;
    assign fifo.recv_px_rd                  = w_px_rd;

    assign buff_size           = r_buff_size;
    assign pivot               = r_pivot;
    assign median_pos          = r_median_pos;
    assign second_median_value = r_second;
    assign buf_wr              = w_buf_wr;
    assign buf_addr            = r_count;
    assign buf_data            = w_buf_wr ? fifo.recv_px_din : '0;
    assign receiving           = (r_state == c_ST_RECV);
    assign recv_done           = (r_state == c_ST_DONE);
    assign recv_count          = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_buff_size  <= '0;
            r_pivot      <= '0;
            r_median_pos <= '0;
            r_second     <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_hdr_ok) begin
                        r_buff_size  <= fifo.recv_buff_size_din;
                        r_pivot      <= fifo.recv_pivot_din;
                        r_median_pos <= fifo.recv_median_pos_din;
                        r_second     <= fifo.recv_second_median_value_din;
                        r_state      <= (fifo.recv_buff_size_din == '0) ? c_ST_DONE : c_ST_RECV;
                    end
                end
                c_ST_RECV: begin
                    // oversize bursts are drained fully so the pixel stream stays aligned
                    if (w_px_rd) begin
                        r_count <= r_count + c_ONE;
                        if (r_count == (r_buff_size - c_ONE)) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_count <= '0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef RECV_LOGIC_SIZE_CHECK_EN
    logic r_size_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size_err <= 1'b0;
        end else if (w_hdr_ok && ((fifo.recv_buff_size_din == '0) ||
                                  (fifo.recv_buff_size_din > c_BUFF_SIZE))) begin
            r_size_err <= 1'b1;
        end
    end

    assign recv_size_err = r_size_err;
`else
    assign recv_size_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_recv_logic.sv
`default_nettype none
// ============================================================================
// Module      : tb_recv_logic
// Description : Self-checking bench for recv_logic; FIFOs and expected
//               behaviour are modelled with queues and burst-level rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_recv_logic;

    localparam int BUFF_SIZE = 32;
    localparam int BSB       = $clog2(BUFF_SIZE) + 1;
    localparam int DW        = 8;
`ifdef RECV_LOGIC_SIZE_CHECK_EN
    localparam bit SIZE_CHECK = 1'b1;
`else
    localparam bit SIZE_CHECK = 1'b0;
`endif

    typedef struct {
        int unsigned size;
        int unsigned pivot;
        int unsigned mpos;
        int unsigned second;
    } hdr_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           recv_req = 1'b0;
    logic [BSB-1:0] buff_size;
    logic [DW-1:0]  pivot;
    logic [BSB-1:0] median_pos;
    logic [DW-1:0]  second_median_value;
    logic           buf_wr;
    logic [BSB-1:0] buf_addr;
    logic [DW-1:0]  buf_data;
    logic           receiving;
    logic           recv_done;
    logic [BSB-1:0] recv_count;
    logic           recv_size_err;

    recv_logic_if #(.BUFF_SIZE(BUFF_SIZE), .BUFF_SIZE_BIT(BSB), .DATA_WIDTH(DW)) fifo_if ();

    recv_logic #(.BUFF_SIZE(BUFF_SIZE), .BUFF_SIZE_BIT(BSB), .DATA_WIDTH(DW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .recv_req            (recv_req),
        .fifo                (fifo_if),
        .buff_size           (buff_size),
        .pivot               (pivot),
        .median_pos          (median_pos),
        .second_median_value (second_median_value),
        .buf_wr              (buf_wr),
        .buf_addr            (buf_addr),
        .buf_data            (buf_data),
        .receiving           (receiving),
        .recv_done           (recv_done),
        .recv_count          (recv_count),
        .recv_size_err       (recv_size_err)
    );

    always #5 clk = ~clk;

    // FIFO contents and burst-level model state
    hdr_t        hq[$];
    logic [7:0]  pq[$];
    bit [3:0]    force_ctrl = 4'b0;
    bit          busy = 1'b0;
    int          pops = 0, cur_n = 0, cyc = 0, hdr_cyc = 0, done_cyc = 0, done_cnt = 0;
    int          stall_lo = 0, stall_hi = 0;
    int unsigned m_size = 0, m_piv = 0, m_mpos = 0, m_sec = 0;
    bit          m_err = 1'b0;
    int          n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bit fpx;
        fpx = busy && ((cyc - hdr_cyc) >= stall_lo) && ((cyc - hdr_cyc) < stall_hi);
        fifo_if.recv_buff_size_empty           = (hq.size() == 0) || force_ctrl[0];
        fifo_if.recv_pivot_empty               = (hq.size() == 0) || force_ctrl[1];
        fifo_if.recv_median_pos_empty          = (hq.size() == 0) || force_ctrl[2];
        fifo_if.recv_second_median_value_empty = (hq.size() == 0) || force_ctrl[3];
        fifo_if.recv_buff_size_din           = (hq.size() != 0) ? BSB'(hq[0].size)   : '0;
        fifo_if.recv_pivot_din               = (hq.size() != 0) ? DW'(hq[0].pivot)   : '0;
        fifo_if.recv_median_pos_din          = (hq.size() != 0) ? BSB'(hq[0].mpos)   : '0;
        fifo_if.recv_second_median_value_din = (hq.size() != 0) ? DW'(hq[0].second)  : '0;
        fifo_if.recv_px_empty = (pq.size() == 0) || fpx;
        fifo_if.recv_px_din   = (pq.size() != 0) ? pq[0] : 8'h00;
    endtask

    // One clock: drive, check everything at negedge, advance the model after posedge
    task automatic step();
        bit   exp_hdr, in_recv, exp_px, exp_wr, exp_done;
        hdr_t h;
        drive();
        @(negedge clk);
        exp_hdr  = rst_n && !busy && recv_req &&
                   !fifo_if.recv_buff_size_empty && !fifo_if.recv_pivot_empty &&
                   !fifo_if.recv_median_pos_empty && !fifo_if.recv_second_median_value_empty;
        in_recv  = busy && (pops < cur_n);
        exp_px   = in_recv && !fifo_if.recv_px_empty;
        exp_wr   = exp_px && (pops < BUFF_SIZE);
        exp_done = busy && (pops == cur_n);
        chk("size_rd",   fifo_if.recv_buff_size_rd, exp_hdr);
        chk("pivot_rd",  fifo_if.recv_pivot_rd, exp_hdr);
        chk("mpos_rd",   fifo_if.recv_median_pos_rd, exp_hdr);
        chk("second_rd", fifo_if.recv_second_median_value_rd, exp_hdr);
        chk("px_rd",     fifo_if.recv_px_rd, exp_px);
        chk("receiving", receiving, in_recv);
        chk("recv_done", recv_done, exp_done);
        chk("buf_wr",    buf_wr, exp_wr);
        if (exp_wr) begin
            chk("buf_addr", buf_addr, pops);
            chk("buf_data", buf_data, pq[0]);
        end
        chk("recv_count", recv_count, busy ? pops : 0);
        chk("buff_size",  buff_size, m_size);
        chk("pivot",      pivot, m_piv);
        chk("median_pos", median_pos, m_mpos);
        chk("second",     second_median_value, m_sec);
        chk("size_err",   recv_size_err, m_err);
        @(posedge clk);
        #1;
        if (exp_hdr) begin
            h = hq.pop_front();
            m_size = h.size; m_piv = h.pivot; m_mpos = h.mpos; m_sec = h.second;
            if (SIZE_CHECK && ((h.size == 0) || (h.size > BUFF_SIZE))) m_err = 1'b1;
            busy = 1'b1; pops = 0; cur_n = int'(h.size); hdr_cyc = cyc;
        end else if (exp_done) begin
            busy = 1'b0; done_cyc = cyc; done_cnt++;
        end else if (exp_px) begin
            void'(pq.pop_front());
            pops++;
        end
        cyc++;
    endtask

    task automatic push_burst(input int n, input int unsigned piv, input int unsigned mp,
                              input int unsigned sec, input bit ramp, input int base);
        hdr_t h;
        h.size = n; h.pivot = piv & 8'hff; h.mpos = mp & 6'h3f; h.second = sec & 8'hff;
        hq.push_back(h);
        for (int i = 0; i < n; i++) pq.push_back(ramp ? 8'(base + i) : 8'($urandom));
    endtask

    task automatic wait_done(input int budget);
        int target;
        target = done_cnt + 1;
        for (int i = 0; i < budget && done_cnt < target; i++) step();
        chk("done_timeout", done_cnt >= target, 1);
    endtask

    // Cycle (relative to header pop) at which recv_done must appear
    function automatic int exp_done_rel(input int n, input int lo, input int hi);
        int c, got;
        c = 1; got = 0;
        while (got < n) begin
            if (!(c >= lo && c < hi)) got++;
            c++;
        end
        return c;
    endfunction

    task automatic run_burst(input int n, input int unsigned piv, input int unsigned mp,
                             input int unsigned sec, input bit ramp, input int base,
                             input int lo, input int len);
        stall_lo = lo; stall_hi = lo + len;
        push_burst(n, piv, mp, sec, ramp, base);
        recv_req = 1'b1;
        wait_done(400);
        chk("done_cycle", done_cyc - hdr_cyc, exp_done_rel(n, lo, lo + len));
        stall_lo = 0; stall_hi = 0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rd"}, {fifo_if.recv_buff_size_rd, fifo_if.recv_pivot_rd,
                            fifo_if.recv_median_pos_rd, fifo_if.recv_second_median_value_rd,
                            fifo_if.recv_px_rd}, 0);
        chk({tag, "_fields"}, {buff_size, pivot, median_pos, second_median_value}, 0);
        chk({tag, "_buf"}, {buf_wr, buf_addr, buf_data}, 0);
        chk({tag, "_status"}, {receiving, recv_done, recv_count, recv_size_err}, 0);
    endtask

    initial begin
        int d;
        // reset state
        drive();
        recv_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // nominal burst
        run_burst(5, 8'h40, 2, 8'h41, 1'b1, 8'h10, 0, 0);
        chk("nom_hdr_fields", {buff_size, pivot, median_pos, second_median_value},
            {6'd5, 8'h40, 6'd2, 8'h41});

        // pixel FIFO stall after the first pixel
        run_burst(3, 8'h11, 1, 8'h22, 1'b0, 0, 2, 2);

        // request and header gating
        recv_req = 1'b0;
        push_burst(4, 8'h33, 1, 8'h44, 1'b0, 0);
        repeat (4) step();
        recv_req = 1'b1;
        force_ctrl = 4'b0010;
        step();
        force_ctrl = 4'b0000;
        wait_done(100);

        // size boundaries
        run_burst(0, 8'h01, 0, 8'h02, 1'b0, 0, 0, 0);
        run_burst(34, 8'h55, 17, 8'h66, 1'b1, 8'h80, 0, 0);

        // back-to-back bursts: next header in the cycle after recv_done
        push_burst(3, 8'h12, 1, 8'h13, 1'b0, 0);
        push_burst(2, 8'h14, 0, 8'h15, 1'b0, 0);
        wait_done(100);
        d = done_cyc;
        wait_done(100);
        chk("b2b_hdr_cycle", hdr_cyc, d + 1);

        // randomized bursts with random stalls
        for (int k = 0; k < 8; k++) begin
            run_burst($urandom_range(0, 40), $urandom, $urandom, $urandom, 1'b0, 0,
                      $urandom_range(1, 6), $urandom_range(0, 3));
        end

        // asynchronous reset mid-burst
        push_burst(8, 8'h77, 4, 8'h78, 1'b0, 0);
        recv_req = 1'b1;
        for (int i = 0; i < 50 && !(busy && pops == 3); i++) step();
        chk("mid_reached", busy && pops == 3, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        busy = 1'b0; pops = 0; cur_n = 0; m_err = 1'b0;
        m_size = 0; m_piv = 0; m_mpos = 0; m_sec = 0;
        pq.delete(); hq.delete();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_burst(2, 8'h99, 1, 8'h9a, 1'b0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
